// File: rtl/snake_datapath.sv
// Snake game datapath: head/prev/curr position registers, body memory
// addressed by addr, 2x2 segment pixel plotter and food-hit detection.
module snake_datapath #(
  parameter int MAX_LEN = 64,
  parameter int X0      = 80,
  parameter int Y0      = 60,
  parameter int STEP    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  dir,
  input  logic [14:0] food_xy,
  input  logic [2:0]  colour_sel,
  input  logic        ld_head,
  input  logic        ld_q_def,
  input  logic        inc_address,
  input  logic        rst_address,
  input  logic        draw_q,
  input  logic        update_head,
  input  logic        ld_head_into_prev,
  input  logic        ld_q_into_curr,
  input  logic        ld_prev_into_q,
  input  logic        ld_curr_into_prev,
  input  logic        draw_curr,
  input  logic        food_en,
  input  logic        inc_length_check,
  input  logic [1:0]  cnt_status,
  output logic [7:0]  x,
  output logic [6:0]  y,
  output logic [2:0]  colour,
  output logic        plot,
  output logic        length_inc
);

  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [AW-1:0] ADDR_MAX = AW'(MAX_LEN - 1);
  localparam int W = 160;
  localparam int H = 120;

  logic [14:0]   head, prev, curr;
  logic [AW-1:0] addr;
  logic [14:0]   mem [MAX_LEN];
  logic [14:0]   q;
  logic [14:0]   q_def;
  logic [14:0]   mem_wd;
  logic          mem_we;
  logic [7:0]    hx, nx;
  logic [6:0]    hy, ny;
  logic [14:0]   base;

  assign q     = mem[addr];
  assign q_def = {8'(X0 - STEP * int'(addr)), 7'(Y0)};
  assign hx    = head[14:7];
  assign hy    = head[6:0];

  // Default body contents win over the shift write when both are requested
  assign mem_we = ld_q_def | ld_prev_into_q;
  assign mem_wd = ld_q_def ? q_def : prev;

  // Next head position with toroidal wrap on the 160x120 playfield
  always_comb begin
    nx = hx;
    ny = hy;
    unique case (dir)
      2'b00: nx = (int'(hx) + STEP >= W) ? 8'(int'(hx) + STEP - W) : 8'(int'(hx) + STEP);
      2'b01: nx = (int'(hx) < STEP)      ? 8'(int'(hx) + W - STEP) : 8'(int'(hx) - STEP);
      2'b10: ny = (int'(hy) < STEP)      ? 7'(int'(hy) + H - STEP) : 7'(int'(hy) - STEP);
      2'b11: ny = (int'(hy) + STEP >= H) ? 7'(int'(hy) + STEP - H) : 7'(int'(hy) + STEP);
    endcase
  end

  // Body memory write port; not reset, and suppressed while rst is low
  always_ff @(posedge clk) begin
    if (rst && mem_we)
      mem[addr] <= mem_wd;
  end

  // Position, address and food-hit registers with asynchronous clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head       <= '0;
      prev       <= '0;
      curr       <= '0;
      addr       <= '0;
      length_inc <= 1'b0;
    end else begin
      if (ld_head)
        head <= {8'(X0), 7'(Y0)};
      else if (update_head)
        head <= {nx, ny};

      if (ld_head_into_prev)
        prev <= head;
      else if (ld_curr_into_prev)
        prev <= curr;

      if (ld_q_into_curr)
        curr <= q;

      if (rst_address)
        addr <= '0;
      else if (inc_address && addr != ADDR_MAX)
        addr <= addr + 1'b1;

      length_inc <= inc_length_check && (head == food_xy);
    end
  end

  // Pixel plot mux: draw_q > draw_curr > food_en, idle outputs all zero
  always_comb begin
    plot   = 1'b0;
    x      = '0;
    y      = '0;
    colour = '0;
    base   = '0;
    if (draw_q) begin
      base   = q;
      plot   = 1'b1;
      colour = colour_sel;
    end else if (draw_curr) begin
      base   = curr;
      plot   = 1'b1;
      colour = 3'b000;
    end else if (food_en) begin
      base   = food_xy;
      plot   = 1'b1;
      colour = colour_sel;
    end
    if (plot) begin
      x = base[14:7] + {7'd0, cnt_status[0]};
      y = base[6:0]  + {6'd0, cnt_status[1]};
    end
  end

endmodule

// File: doc/snake_datapath.md
SNAKE_DATAPATH -- requirements
Module: snake_datapath

Interface
REQ-001 Parameters SHALL be (name, default, meaning): MAX_LEN, 64, body memory depth in segments; X0, 80, initial head x (even); Y0, 60, initial head y (even); STEP, 2, segment size and move distance in pixels.
REQ-002 Ports SHALL be (name direction width meaning): clk in 1 clock.
REQ-003 rst in 1 reset, asynchronous, active-low.
REQ-004 dir in 2 move direction: 00 right, 01 left, 10 up, 11 down.
REQ-005 food_xy in 15 food position {x[7:0], y[6:0]}.
REQ-006 colour_sel in 3 colour for draw_q and food_en plots.
REQ-007 ld_head, ld_q_def, inc_address, rst_address, draw_q, update_head, ld_head_into_prev, ld_q_into_curr, ld_prev_into_q, ld_curr_into_prev, draw_curr, food_en, inc_length_check in 1 each: single-cycle control strobes.
REQ-008 cnt_status in 2 pixel index within a 2x2 segment.
REQ-009 x out 8, y out 7, colour out 3, plot out 1: pixel write to the frame buffer.
REQ-010 length_inc out 1 one-cycle pulse when the head reaches the food.

Function
REQ-011 The block SHALL hold registers head, prev and curr (15 bits each, {x,y}), an address register addr (clog2(MAX_LEN) bits) and a body memory of MAX_LEN x 15 bits.
REQ-012 q SHALL be mem[addr], read combinationally; a write is visible in q the cycle after the write edge.
REQ-013 ld_head: head <= {X0, Y0}.
REQ-014 ld_q_def: mem[addr] <= {X0 - STEP*addr, Y0}, x truncated to 8 bits.
REQ-015 inc_address: addr <= addr+1, saturating at MAX_LEN-1; rst_address: addr <= 0; rst_address SHALL win when both are asserted.
REQ-016 update_head: move head by STEP in dir; x wraps modulo 160 (right from 158 -> 0, left from 0 -> 158); y wraps modulo 120 (up from 0 -> 118, down from 118 -> 0).
REQ-017 ld_head_into_prev: prev <= head; ld_q_into_curr: curr <= q; ld_prev_into_q: mem[addr] <= prev; ld_curr_into_prev: prev <= curr (addr increments via REQ-015 when inc_address is also asserted).
REQ-018 If ld_q_def and ld_prev_into_q are asserted together, ld_q_def SHALL win.
REQ-019 Plot output SHALL be combinational from the strobes, with priority draw_q > draw_curr > food_en.
REQ-020 Base position SHALL be q for draw_q, curr for draw_curr and food_xy for food_en.
REQ-021 x SHALL be base.x + cnt_status[0] and y SHALL be base.y + cnt_status[1].
REQ-022 colour SHALL be colour_sel for draw_q and food_en, and 3'b000 for draw_curr (tail erase).
REQ-023 With no draw strobe asserted, plot, x, y and colour SHALL be 0.
REQ-024 inc_length_check: on the next edge, length_inc <= (head == food_xy); otherwise length_inc <= 0, so the pulse lasts exactly one cycle.
REQ-025 inc_length_check SHALL compare the head value as updated by any prior update_head.
REQ-026 An unrecognised combination of strobes SHALL NOT corrupt registers not addressed by an asserted strobe.

Reset
REQ-027 rst low SHALL immediately clear head, prev, curr, addr and length_inc to 0, independent of clk.
REQ-028 Body memory SHALL NOT be reset; its contents are undefined until written by ld_q_def.
REQ-029 Reset asserted mid-operation SHALL abort the sequence, and no write SHALL occur on the edge where rst is low.

Verification
REQ-030 Reset; pulse ld_head, then (ld_q_def, inc_address) three times -> head={80,60}, mem[0..2]={80,60},{78,60},{76,60}, addr=3.
REQ-031 addr=1, draw_q held with cnt_status 0..3 and colour_sel=111 -> plot=1 at (78,60),(79,60),(78,61),(79,61), colour=111.
REQ-032 head.x=158, dir=00, update_head -> head.x=0; head.y=0, dir=10, update_head -> head.y=118.
REQ-033 head=food_xy={40,30}, inc_length_check -> length_inc=1 for exactly one cycle; with food_xy={42,30} -> length_inc stays 0.
REQ-034 Length-3 body, update_head then the shift sequence (ld_head_into_prev, then ld_q_into_curr / ld_prev_into_q / ld_curr_into_prev per segment) -> mem[0]=new head, mem[1..2]=old mem[0..1], curr=old tail; draw_curr with cnt_status=0 -> plot at the old tail, colour=000.
REQ-035 Assert rst low between clock edges during the shift sequence -> addr, head and length_inc are 0 before the next edge, and plot=0.
